// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Opcode fields, register codes, FSM states and one-hot control
//               constants shared by the control sequencer files.
// Revision    : 1.0  initial release
// ============================================================================
package control_sequencer_pkg;

    localparam int REG_N = 4;
    localparam int MUX_W = 5;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MISC = 2'b11;

    localparam logic [1:0] SUB_LDI  = 2'b00;
    localparam logic [1:0] SUB_OUT  = 2'b01;
    localparam logic [1:0] SUB_NOP  = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;
    localparam logic [1:0] REG_C = 2'b10;
    localparam logic [1:0] REG_D = 2'b11;

    localparam logic [MUX_W-1:0] MUX_NONE = 5'b00000;
    localparam logic [MUX_W-1:0] MUX_BUF0 = 5'b00001;
    localparam logic [1:0]       BUF_NONE    = 2'b00;
    localparam logic [1:0]       BUF_OPERAND = 2'b10;
    localparam logic [1:0]       BUF_RESULT  = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_MOV   = 3'd1,
        ST_ALU1  = 3'd2,
        ST_ALU2  = 3'd3,
        ST_ALU3  = 3'd4,
        ST_LDI   = 3'd5,
        ST_OUT   = 3'd6,
        ST_HALT  = 3'd7
    } state_t;

    // Register A sits in the MSB of both the enable and mux vectors.
    function automatic logic [REG_N-1:0] reg_onehot(input logic [1:0] code);
        return 4'b1000 >> code;
    endfunction

    function automatic logic [MUX_W-1:0] mux_onehot(input logic [1:0] code);
        return 5'b10000 >> code;
    endfunction

    function automatic state_t op_state(input logic [7:0] instr);
        state_t st;
        case (instr[7:6])
            OP_MOV:  st = ST_MOV;
            OP_ADD,
            OP_SUB:  st = ST_ALU1;
            default: begin
                case (instr[1:0])
                    SUB_LDI: st = ST_LDI;
                    SUB_OUT: st = ST_OUT;
                    SUB_NOP: st = ST_FETCH;
                    default: st = ST_HALT;
                endcase
            end
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Instruction fetch, bus handshakes and datapath control bundle
//               between the sequencer (master) and its environment (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [7:0]       instr_i;
    logic             instr_valid_i;
    logic             instr_ready_o;
    logic             ext_valid_i;
    logic             ext_ready_o;
    logic             out_ready_i;
    logic             out_strobe_o;
    logic             alu_result_sign_i;
    logic [REG_N-1:0] ger_register_en_o;
    logic [1:0]       alu_buffer_en_o;
    logic [MUX_W-1:0] mux1_ctl_o;
    logic             alu_add_o;
    logic             alu_sub_o;
    logic             r_en_o;
    logic             w_en_o;
    logic             sign_flag_o;
    logic             halted_o;

    modport master (
        input  instr_i, instr_valid_i, ext_valid_i, out_ready_i, alu_result_sign_i,
        output instr_ready_o, ext_ready_o, out_strobe_o, ger_register_en_o,
               alu_buffer_en_o, mux1_ctl_o, alu_add_o, alu_sub_o, r_en_o, w_en_o,
               sign_flag_o, halted_o
    );

    modport slave (
        output instr_i, instr_valid_i, ext_valid_i, out_ready_i, alu_result_sign_i,
        input  instr_ready_o, ext_ready_o, out_strobe_o, ger_register_en_o,
               alu_buffer_en_o, mux1_ctl_o, alu_add_o, alu_sub_o, r_en_o, w_en_o,
               sign_flag_o, halted_o
    );

endinterface
`default_nettype wire

// File: rtl/control_sequencer_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : seq_decode
// Description : Combinational decode of sequencer state and IR fields into
//               handshake and datapath control outputs.
// Revision    : 1.0  initial release
// ============================================================================
module seq_decode
    import control_sequencer_pkg::*;
(
    input  wire logic             rst_i,
    input  wire state_t           state_i,
    input  wire logic [1:0]       op_i,
    input  wire logic [1:0]       dst_i,
    input  wire logic [1:0]       src_i,
    input  wire logic             ext_valid_i,
    output logic                  instr_ready_o,
    output logic                  ext_ready_o,
    output logic                  out_strobe_o,
    output logic [REG_N-1:0]      ger_en_o,
    output logic [1:0]            buf_en_o,
    output logic [MUX_W-1:0]      mux_o,
    output logic                  add_o,
    output logic                  sub_o,
    output logic                  r_en_o,
    output logic                  w_en_o
);

    always_comb begin
        instr_ready_o = 1'b0;
        ext_ready_o   = 1'b0;
        out_strobe_o  = 1'b0;
        ger_en_o      = '0;
        buf_en_o      = BUF_NONE;
        mux_o         = MUX_NONE;
        add_o         = 1'b0;
        sub_o         = 1'b0;
        r_en_o        = 1'b0;
        w_en_o        = 1'b0;
        // Everything is gated by reset so the datapath cannot load mid-reset.
        if (!rst_i) begin
            case (state_i)
                ST_FETCH: instr_ready_o = 1'b1;
                ST_MOV: begin
                    mux_o    = mux_onehot(src_i);
                    ger_en_o = reg_onehot(dst_i);
                end
                ST_ALU1: begin
                    mux_o    = mux_onehot(dst_i);
                    buf_en_o = BUF_OPERAND;
                end
                ST_ALU2: begin
                    mux_o    = mux_onehot(src_i);
                    add_o    = (op_i == OP_ADD);
                    sub_o    = (op_i == OP_SUB);
                    buf_en_o = BUF_RESULT;
                end
                ST_ALU3: begin
                    mux_o    = MUX_BUF0;
                    ger_en_o = reg_onehot(dst_i);
                end
                ST_LDI: begin
                    r_en_o = 1'b1;
                    if (ext_valid_i) begin
                        ger_en_o    = reg_onehot(dst_i);
                        ext_ready_o = 1'b1;
                    end
                end
                ST_OUT: begin
                    mux_o        = mux_onehot(src_i);
                    w_en_o       = 1'b1;
                    out_strobe_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle instruction sequencer driving the 8-bit operation
//               unit; holds the FSM, instruction register and status flags.
// Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    control_sequencer_if.master bus
);

    state_t     state_q;
    logic [7:0] ir_q;
    logic       sign_q;
    logic       halted_q;
    state_t     w_fetch_next;
    logic       w_unused_sub;

    assign w_fetch_next = op_state(bus.instr_i);
    // The sub field only steers the FETCH transition, which reads instr_i directly.
    assign w_unused_sub = ^ir_q[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            sign_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.instr_valid_i) begin
                        ir_q     <= bus.instr_i;
                        state_q  <= w_fetch_next;
                        halted_q <= (w_fetch_next == ST_HALT);
                    end
                end
                ST_MOV:  state_q <= ST_FETCH;
                ST_ALU1: state_q <= ST_ALU2;
                ST_ALU2: begin
                    sign_q  <= bus.alu_result_sign_i;
                    state_q <= ST_ALU3;
                end
                ST_ALU3: state_q <= ST_FETCH;
                ST_LDI: begin
                    if (bus.ext_valid_i) state_q <= ST_FETCH;
                end
                ST_OUT: begin
                    if (bus.out_ready_i) state_q <= ST_FETCH;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    seq_decode u_decode (
        .rst_i         (rst_i),
        .state_i       (state_q),
        .op_i          (ir_q[7:6]),
        .dst_i         (ir_q[5:4]),
        .src_i         (ir_q[3:2]),
        .ext_valid_i   (bus.ext_valid_i),
        .instr_ready_o (bus.instr_ready_o),
        .ext_ready_o   (bus.ext_ready_o),
        .out_strobe_o  (bus.out_strobe_o),
        .ger_en_o      (bus.ger_register_en_o),
        .buf_en_o      (bus.alu_buffer_en_o),
        .mux_o         (bus.mux1_ctl_o),
        .add_o         (bus.alu_add_o),
        .sub_o         (bus.alu_sub_o),
        .r_en_o        (bus.r_en_o),
        .w_en_o        (bus.w_en_o)
    );

    assign bus.sign_flag_o = sign_q;
    assign bus.halted_o    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Scoreboard bench for control_sequencer; each entry holds one
//               cycle of stimulus and the full expected output vector.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ins;
        logic        iv;
        logic        ev;
        logic        ordy;
        logic        sgn;
        logic        r;
        logic [19:0] exp;
    } ent_t;

    ent_t sb[$];

    // {instr_ready, ext_ready, out_strobe, ger[3:0], buf[1:0], mux[4:0], add, sub, r_en, w_en, sign, halted}
    function automatic logic [19:0] ex(logic rdy, logic xr, logic st, logic [3:0] g, logic [1:0] b,
                                       logic [4:0] m, logic a, logic s, logic re, logic we,
                                       logic sf, logic h);
        return {rdy, xr, st, g, b, m, a, s, re, we, sf, h};
    endfunction

    function automatic void p(logic [7:0] ins, logic iv, logic ev, logic ordy, logic sgn, logic r,
                              logic [19:0] e);
        sb.push_back({ins, iv, ev, ordy, sgn, r, e});
    endfunction

    function automatic logic [19:0] observe();
        return {bus.instr_ready_o, bus.ext_ready_o, bus.out_strobe_o, bus.ger_register_en_o,
                bus.alu_buffer_en_o, bus.mux1_ctl_o, bus.alu_add_o, bus.alu_sub_o,
                bus.r_en_o, bus.w_en_o, bus.sign_flag_o, bus.halted_o};
    endfunction

    function automatic void apply(ent_t e);
        bus.instr_i           = e.ins;
        bus.instr_valid_i     = e.iv;
        bus.ext_valid_i       = e.ev;
        bus.out_ready_i       = e.ordy;
        bus.alu_result_sign_i = e.sgn;
        rst                   = e.r;
    endfunction

    task automatic test_reset();
        ent_t e; logic [19:0] obs;
        p(8'h00, 0, 0, 0, 0, 1, ex(0,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL reset cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mov();
        ent_t e; logic [19:0] obs;
        p(8'h00, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h00, 0, 1, 1, 1, 0, ex(0,0,0,4'b1000,2'b00,5'b10000,0,0,0,0,0,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL mov cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        ent_t e; logic [19:0] obs;
        p(8'h46, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h46, 0, 0, 0, 1, 0, ex(0,0,0,4'b0000,2'b10,5'b10000,0,0,0,0,0,0));
        p(8'h46, 0, 0, 0, 0, 0, ex(0,0,0,4'b0000,2'b01,5'b01000,1,0,0,0,0,0));
        p(8'h46, 0, 0, 0, 1, 0, ex(0,0,0,4'b1000,2'b00,5'b00001,0,0,0,0,0,0));
        p(8'h00, 0, 0, 0, 1, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL add cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sub();
        ent_t e; logic [19:0] obs;
        p(8'h89, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h89, 0, 0, 0, 0, 0, ex(0,0,0,4'b0000,2'b10,5'b10000,0,0,0,0,0,0));
        p(8'h89, 0, 0, 0, 1, 0, ex(0,0,0,4'b0000,2'b01,5'b00100,0,1,0,0,0,0));
        p(8'h89, 0, 0, 0, 0, 0, ex(0,0,0,4'b1000,2'b00,5'b00001,0,0,0,0,1,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL sub cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldi();
        ent_t e; logic [19:0] obs;
        p(8'hE0, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int i = 0; i < 3; i++)
            p(8'hE0, 1, 0, 1, 0, 0, ex(0,0,0,4'b0000,2'b00,5'b00000,0,0,1,0,1,0));
        p(8'hE0, 0, 1, 0, 0, 0, ex(0,1,0,4'b0010,2'b00,5'b00000,0,0,1,0,1,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL ldi cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_out();
        ent_t e; logic [19:0] obs;
        p(8'hCD, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int i = 0; i < 2; i++)
            p(8'hCD, 1, 1, 0, 0, 0, ex(0,0,1,4'b0000,2'b00,5'b00010,0,0,0,1,1,0));
        p(8'hCD, 0, 0, 1, 0, 0, ex(0,0,1,4'b0000,2'b00,5'b00010,0,0,0,1,1,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL out cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // instr_valid_i stays high through MOV; the byte offered there must be ignored.
    task automatic test_back_to_back();
        ent_t e; logic [19:0] obs;
        p(8'h14, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        p(8'h36, 1, 0, 0, 0, 0, ex(0,0,0,4'b0100,2'b00,5'b01000,0,0,0,0,1,0));
        p(8'h36, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        p(8'h36, 0, 0, 0, 0, 0, ex(0,0,0,4'b0001,2'b00,5'b01000,0,0,0,0,1,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL b2b cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        ent_t e; logic [19:0] obs;
        p(8'hC3, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,0));
        for (int i = 0; i < 2; i++)
            p(8'h00, 1, 1, 1, 0, 0, ex(0,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,1));
        p(8'h00, 1, 0, 0, 0, 1, ex(0,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,1,1));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL halt cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_alu2();
        ent_t e; logic [19:0] obs;
        p(8'h46, 1, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h46, 0, 0, 0, 0, 0, ex(0,0,0,4'b0000,2'b10,5'b10000,0,0,0,0,0,0));
        p(8'h46, 0, 0, 0, 1, 1, ex(0,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h00, 0, 0, 0, 1, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        p(8'h00, 0, 0, 0, 0, 0, ex(1,0,0,4'b0000,2'b00,5'b00000,0,0,0,0,0,0));
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front(); apply(e);
            @(negedge clk); obs = observe(); checks++;
            if (obs !== e.exp) begin
                errors++; $display("FAIL rst_alu2 cyc%0d got=%b want=%b", k, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.instr_i           = 8'h00;
        bus.instr_valid_i     = 1'b0;
        bus.ext_valid_i       = 1'b0;
        bus.out_ready_i       = 1'b0;
        bus.alu_result_sign_i = 1'b0;
        rst                   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mov();
        test_add();
        test_sub();
        test_ldi();
        test_out();
        test_back_to_back();
        test_halt();
        test_reset_alu2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
